// File: rtl/cv32e40x_rvfi_instr_pipe.sv
// Shadow pipeline carrying the IF-aligned instruction OBI packet through ID, EX and WB for RVFI.
// Optional retire counter is built when CV32E40X_RVFI_INSTR_PIPE_CNT_EN is defined; otherwise retire_cnt_o is 0.

package cv32e40x_rvfi_instr_pipe_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  mpu_status;
    } rvfi_obi_instr_t;

endpackage

module cv32e40x_rvfi_instr_pipe
    import cv32e40x_rvfi_instr_pipe_pkg::*;
#(
    parameter bit CLEAR_ON_KILL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  rvfi_obi_instr_t obi_instr_i,
    input  logic            if_valid_i,
    input  logic            id_ready_i,
    input  logic            id_valid_i,
    input  logic            ex_ready_i,
    input  logic            ex_valid_i,
    input  logic            wb_ready_i,
    input  logic            wb_valid_i,
    input  logic            kill_id_i,
    input  logic            kill_ex_i,
    input  logic            kill_wb_i,
    output rvfi_obi_instr_t obi_instr_wb_o,
    output logic            obi_valid_wb_o,
    output logic            protocol_err_o,
    output logic [63:0]     retire_cnt_o
);

    rvfi_obi_instr_t r_pkt_id;
    rvfi_obi_instr_t r_pkt_ex;
    rvfi_obi_instr_t r_pkt_wb;
    logic            r_v_id;
    logic            r_v_ex;
    logic            r_v_wb;
    logic            r_protocol_err;

    logic w_t_if_id;
    logic w_t_id_ex;
    logic w_t_ex_wb;
    logic w_ret;
    logic w_protocol_err;

    assign w_t_if_id = if_valid_i && id_ready_i;
    assign w_t_id_ex = id_valid_i && ex_ready_i;
    assign w_t_ex_wb = ex_valid_i && wb_ready_i;
    assign w_ret     = wb_valid_i;

    // A transfer out of an empty stage is flagged, but still moves the (invalid) packet along.
    assign w_protocol_err = (w_t_id_ex && !r_v_id) ||
                            (w_t_ex_wb && !r_v_ex) ||
                            (w_ret     && !r_v_wb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_id <= '0;
            r_v_id   <= 1'b0;
        end else if (kill_id_i) begin
            r_v_id <= 1'b0;
            if (CLEAR_ON_KILL) begin
                r_pkt_id <= '0;
            end
        end else if (w_t_if_id) begin
            r_pkt_id <= obi_instr_i;
            r_v_id   <= 1'b1;
        end else if (w_t_id_ex) begin
            r_v_id <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_ex <= '0;
            r_v_ex   <= 1'b0;
        end else if (kill_ex_i) begin
            r_v_ex <= 1'b0;
            if (CLEAR_ON_KILL) begin
                r_pkt_ex <= '0;
            end
        end else if (w_t_id_ex) begin
            r_pkt_ex <= r_pkt_id;
            r_v_ex   <= r_v_id;
        end else if (w_t_ex_wb) begin
            r_v_ex <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_wb <= '0;
            r_v_wb   <= 1'b0;
        end else if (kill_wb_i) begin
            r_v_wb <= 1'b0;
            if (CLEAR_ON_KILL) begin
                r_pkt_wb <= '0;
            end
        end else if (w_t_ex_wb) begin
            r_pkt_wb <= r_pkt_ex;
            r_v_wb   <= r_v_ex;
        end else if (w_ret) begin
            r_v_wb <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_err <= 1'b0;
        end else begin
            r_protocol_err <= w_protocol_err;
        end
    end

`ifdef CV32E40X_RVFI_INSTR_PIPE_CNT_EN
    logic [63:0] r_retire_cnt;

    // A kill in the same cycle does not cancel the retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_ret && r_v_wb) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt_o = r_retire_cnt;
`else
    assign retire_cnt_o = 64'h0;
`endif

    assign obi_instr_wb_o = r_pkt_wb;
    assign obi_valid_wb_o = r_v_wb;
    assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_cv32e40x_rvfi_instr_pipe.sv
// Randomized and directed bench for cv32e40x_rvfi_instr_pipe against a stage-table reference model.
// Honours CV32E40X_RVFI_INSTR_PIPE_CNT_EN for the expected retire count.

module tb_cv32e40x_rvfi_instr_pipe;
    import cv32e40x_rvfi_instr_pipe_pkg::*;

    localparam bit CLR = 1'b1;

    logic            clk = 1'b0;
    logic            rst_n;
    rvfi_obi_instr_t obi_in;
    logic            if_valid, id_ready, id_valid, ex_ready, ex_valid, wb_ready, wb_valid;
    logic            kill_id, kill_ex, kill_wb;
    rvfi_obi_instr_t obi_wb;
    logic            v_wb;
    logic            perr;
    logic [63:0]     cnt;

    cv32e40x_rvfi_instr_pipe #(.CLEAR_ON_KILL(CLR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .obi_instr_i    (obi_in),
        .if_valid_i     (if_valid),
        .id_ready_i     (id_ready),
        .id_valid_i     (id_valid),
        .ex_ready_i     (ex_ready),
        .ex_valid_i     (ex_valid),
        .wb_ready_i     (wb_ready),
        .wb_valid_i     (wb_valid),
        .kill_id_i      (kill_id),
        .kill_ex_i      (kill_ex),
        .kill_wb_i      (kill_wb),
        .obi_instr_wb_o (obi_wb),
        .obi_valid_wb_o (v_wb),
        .protocol_err_o (perr),
        .retire_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 = ID, 1 = EX, 2 = WB.
    rvfi_obi_instr_t m_pkt [3];
    logic            m_v   [3];
    logic            m_err;
    logic [63:0]     m_cnt;

    function automatic logic [63:0] cnt_exp(input logic [63:0] n);
`ifdef CV32E40X_RVFI_INSTR_PIPE_CNT_EN
        return n;
`else
        return 64'h0;
`endif
    endfunction

    function automatic rvfi_obi_instr_t mkpkt(input logic [31:0] addr);
        rvfi_obi_instr_t p;
        p.addr       = addr;
        p.rdata      = ~addr ^ 32'h1357_9bdf;
        p.err        = addr[4];
        p.mpu_status = addr[3:2];
        return p;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_pkt[s] = '0;
            m_v[s]   = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    // Each stage: kill beats fill beats drain; fill source is the stage upstream (IF for ID).
    task automatic model_edge();
        rvfi_obi_instr_t op [3];
        logic            ov [3];
        logic            fill [3];
        logic            drain [3];
        logic            kill [3];
        rvfi_obi_instr_t src [3];
        logic            srcv [3];
        for (int s = 0; s < 3; s++) begin
            op[s] = m_pkt[s];
            ov[s] = m_v[s];
        end
        fill[0] = if_valid && id_ready;
        fill[1] = id_valid && ex_ready;
        fill[2] = ex_valid && wb_ready;
        drain[0] = fill[1];
        drain[1] = fill[2];
        drain[2] = wb_valid;
        kill[0] = kill_id;
        kill[1] = kill_ex;
        kill[2] = kill_wb;
        src[0] = obi_in; srcv[0] = 1'b1;
        src[1] = op[0];  srcv[1] = ov[0];
        src[2] = op[1];  srcv[2] = ov[1];
        m_err = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (drain[s] && !ov[s]) m_err = 1'b1;
        end
        if (wb_valid && ov[2]) m_cnt = m_cnt + 64'd1;
        for (int s = 0; s < 3; s++) begin
            if (kill[s]) begin
                m_v[s] = 1'b0;
                if (CLR) m_pkt[s] = '0;
            end else if (fill[s]) begin
                m_pkt[s] = src[s];
                m_v[s]   = srcv[s];
            end else if (drain[s]) begin
                m_v[s] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("wb_pkt", 128'(obi_wb), 128'(m_pkt[2]));
        check_eq("wb_valid", 128'(v_wb), 128'(m_v[2]));
        check_eq("protocol_err", 128'(perr), 128'(m_err));
        check_eq("retire_cnt", 128'(cnt), 128'(cnt_exp(m_cnt)));
    endtask

    task automatic idle();
        obi_in = '0;
        {if_valid, id_ready, id_valid, ex_ready, ex_valid, wb_ready, wb_valid} = '0;
        {kill_id, kill_ex, kill_wb} = '0;
    endtask

    // One cycle: push/move flags per boundary, valids follow the model so no protocol error.
    task automatic cyc(input logic push, input logic [31:0] addr, input logic mv_id_ex,
                       input logic mv_ex_wb, input logic ret, input logic kid);
        idle();
        if_valid = push;
        id_ready = push;
        obi_in   = mkpkt(addr);
        id_valid = m_v[0];
        ex_ready = mv_id_ex;
        ex_valid = m_v[1];
        wb_ready = mv_ex_wb;
        wb_valid = ret;
        kill_id  = kid;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cnt_before;
        idle();
        model_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst_pkt", 128'(obi_wb), 128'h0);
        check_eq("rst_valid", 128'(v_wb), 128'h0);
        check_eq("rst_perr", 128'(perr), 128'h0);
        check_eq("rst_cnt", 128'(cnt), 128'h0);
        #10 rst_n = 1'b1;

        // Stream A,B,C with every handshake open.
        for (int i = 0; i < 9; i++) begin
            cyc(i < 3, 32'h80 + 32'(4 * i), 1'b1, 1'b1, m_v[2], 1'b0);
            if (i >= 2 && i <= 4) begin
                check_eq("stream_addr", 128'(obi_wb.addr), 128'(32'h80 + 32'(4 * (i - 2))));
                check_eq("stream_valid", 128'(v_wb), 128'h1);
            end
        end
        check_eq("stream_cnt", 128'(cnt), 128'(cnt_exp(64'd3)));

        // Stall in EX for five cycles.
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("stall_wb_valid", 128'(v_wb), 128'h0);
            check_eq("stall_wb_addr", 128'(obi_wb.addr), 128'h88);
            check_eq("stall_ex_addr", 128'(dut.r_pkt_ex.addr), 128'h100);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("stall_release_addr", 128'(obi_wb.addr), 128'h100);
        check_eq("stall_release_valid", 128'(v_wb), 128'h1);

        // Drain + refill in WB.
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("refill_pre_addr", 128'(obi_wb.addr), 128'h300);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("refill_addr", 128'(obi_wb.addr), 128'h304);
        check_eq("refill_valid", 128'(v_wb), 128'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Kill ID while it is being filled.
        cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("kill_v_id", 128'(dut.r_v_id), 128'h0);
        check_eq("kill_pkt_id", 128'(dut.r_pkt_id), 128'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            check_eq("kill_never_wb", 128'(v_wb), 128'h0);
        end

        // Retire with WB empty.
        cnt_before = m_cnt;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("perr_pulse", 128'(perr), 128'h1);
        check_eq("perr_cnt", 128'(cnt), 128'(cnt_exp(cnt_before)));
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("perr_clear", 128'(perr), 128'h0);

        // Randomized traffic including kills and occasional illegal transfers.
        for (int i = 0; i < 600; i++) begin
            idle();
            if_valid = ($urandom_range(0, 9) < 7);
            id_ready = ($urandom_range(0, 3) != 0);
            obi_in   = mkpkt({$urandom_range(0, 32'h3fff_ffff), 2'b00});
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            id_valid = ($urandom_range(0, 19) == 0) ? ~m_v[0] : m_v[0];
            ex_valid = ($urandom_range(0, 19) == 0) ? ~m_v[1] : m_v[1];
            wb_valid = ($urandom_range(0, 19) == 0) ? ~m_v[2] : (m_v[2] && $urandom_range(0, 3) != 0);
            kill_id  = ($urandom_range(0, 19) == 0);
            kill_ex  = ($urandom_range(0, 19) == 0);
            kill_wb  = ($urandom_range(0, 19) == 0);
            step();
        end

        // Fill all stages, then reset asynchronously mid-cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check_eq("prereset_valid", 128'(v_wb), 128'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 128'(v_wb), 128'h0);
        check_eq("async_rst_pkt", 128'(obi_wb), 128'h0);
        check_eq("async_rst_cnt", 128'(cnt), 128'h0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
